// File: rtl/cc_cnt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cc_cnt_pkg
// Brief    : Shared types and Gray/popcount helpers for the cross-clock counter.
// Revision : 1.0
// ============================================================================
package cc_cnt_pkg;

    localparam int unsigned CC_MAX_W = 32;
    localparam int unsigned CC_CNT_W = 6;

    typedef enum logic [0:0] {
        S_FILL  = 1'b0,
        S_TRACK = 1'b1
    } state_t;

    // Helpers run at CC_MAX_W; zero-extending the operand leaves the low bits
    // of the Gray/binary conversions exact for any narrower width.
    function automatic logic [CC_MAX_W-1:0] gray2bin(input logic [CC_MAX_W-1:0] g);
        logic [CC_MAX_W-1:0] b;
        b[CC_MAX_W-1] = g[CC_MAX_W-1];
        for (int i = CC_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [CC_MAX_W-1:0] bin2gray(input logic [CC_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [CC_CNT_W-1:0] popcount(input logic [CC_MAX_W-1:0] v);
        logic [CC_CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < CC_MAX_W; i++) begin
            n = n + CC_CNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdc_sync_ff.sv
`default_nettype none
// ============================================================================
// Module   : cdc_sync_ff
// Brief    : Multi-flop synchronizer chain with synchronous reset to zero.
// Revision : 1.0
// ============================================================================
module cdc_sync_ff #(
    parameter int unsigned W      = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_sync
);

    logic [W-1:0] sync_q [STAGES];
    logic [W-1:0] sync_d [STAGES];

    always_comb begin
        sync_d[0] = i_data;
        for (int i = 1; i < int'(STAGES); i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(STAGES); i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign o_sync = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/cc_cnt_gray_rx.sv
`default_nettype none
// ============================================================================
// Module   : cc_cnt_gray_rx
// Brief    : Receives a foreign-domain Gray count and turns advances into events.
// Revision : 1.0
// ============================================================================
module cc_cnt_gray_rx
    import cc_cnt_pkg::*;
#(
    parameter int unsigned W           = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PEND_W      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W-1:0]      gray_in,
    output logic [W-1:0]      cnt_out,
    output logic [W-1:0]      delta_out,
    output logic              step_err,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              pend_ovf
);

    localparam int unsigned       c_fill_w    = $clog2(SYNC_STAGES + 1);
    localparam int unsigned       c_sum_w     = PEND_W + W + 1;
    localparam logic [PEND_W-1:0] c_pend_max  = '1;
    localparam logic [c_fill_w-1:0] c_fill_last = c_fill_w'(SYNC_STAGES);

    logic [W-1:0]        w_sync_g;
    logic [W-1:0]        w_bin;
    logic [W-1:0]        w_delta;
    logic [W-1:0]        w_add;
    logic                w_multi;
    logic                w_pop;
    logic [c_sum_w-1:0]  w_pend_sum;

    state_t              state_q, state_d;
    logic [c_fill_w-1:0] fill_q, fill_d;
    logic [W-1:0]        prev_g_q, prev_g_d;
    logic [W-1:0]        prev_bin_q, prev_bin_d;
    logic [W-1:0]        cnt_q, cnt_d;
    logic [W-1:0]        delta_q, delta_d;
    logic                step_err_q, step_err_d;
    logic                evt_valid_q, evt_valid_d;
    logic                pend_ovf_q, pend_ovf_d;
    logic [PEND_W-1:0]   pend_q, pend_d;

    cdc_sync_ff #(
        .W      (W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .i_data (gray_in),
        .o_sync (w_sync_g)
    );

    always_comb begin
        w_bin      = W'(gray2bin(CC_MAX_W'(w_sync_g)));
        w_delta    = w_bin - prev_bin_q;
        w_multi    = popcount(CC_MAX_W'(w_sync_g ^ prev_g_q)) > CC_CNT_W'(1);
        w_pop      = evt_valid_q & evt_ready;
        w_add      = '0;

        state_d    = state_q;
        fill_d     = fill_q;
        delta_d    = delta_q;
        step_err_d = step_err_q;
        pend_ovf_d = pend_ovf_q;
        prev_g_d   = w_sync_g;
        prev_bin_d = w_bin;
        cnt_d      = w_bin;

        case (state_q)
            S_FILL: begin
                // Sample taken on the final fill cycle is the tracking baseline.
                if (fill_q == c_fill_last) begin
                    state_d = S_TRACK;
                end else begin
                    fill_d = fill_q + c_fill_w'(1);
                end
            end
            S_TRACK: begin
                if (w_delta != '0) begin
                    w_add   = w_delta;
                    delta_d = w_delta;
                    if (w_multi) begin
                        step_err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_FILL;
        endcase

        // Pop only happens with a nonzero count, so the sum never goes negative.
        w_pend_sum = c_sum_w'(pend_q) + c_sum_w'(w_add) - c_sum_w'(w_pop);
        if (w_pend_sum > c_sum_w'(c_pend_max)) begin
            pend_d     = c_pend_max;
            pend_ovf_d = 1'b1;
        end else begin
            pend_d     = PEND_W'(w_pend_sum);
        end
        evt_valid_d = (pend_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FILL;
            fill_q      <= '0;
            prev_g_q    <= '0;
            prev_bin_q  <= '0;
            cnt_q       <= '0;
            delta_q     <= '0;
            step_err_q  <= 1'b0;
            evt_valid_q <= 1'b0;
            pend_ovf_q  <= 1'b0;
            pend_q      <= '0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            prev_g_q    <= prev_g_d;
            prev_bin_q  <= prev_bin_d;
            cnt_q       <= cnt_d;
            delta_q     <= delta_d;
            step_err_q  <= step_err_d;
            evt_valid_q <= evt_valid_d;
            pend_ovf_q  <= pend_ovf_d;
            pend_q      <= pend_d;
        end
    end

    assign cnt_out   = cnt_q;
    assign delta_out = delta_q;
    assign step_err  = step_err_q;
    assign evt_valid = evt_valid_q;
    assign pend_cnt  = pend_q;
    assign pend_ovf  = pend_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_cc_cnt_gray_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_cc_cnt_gray_rx
// Brief    : Directed scenarios plus random walk against a count-level model.
// Revision : 1.0
// ============================================================================
module tb_cc_cnt_gray_rx;

    localparam int TB_W     = 8;
    localparam int TB_S     = 2;
    localparam int TB_P     = 3;
    localparam int PEND_MAX = (1 << TB_P) - 1;

    logic            clk       = 1'b0;
    logic            rst       = 1'b1;
    logic            evt_ready = 1'b0;
    logic [TB_W-1:0] gray_in   = '0;
    logic [TB_W-1:0] cnt_out;
    logic [TB_W-1:0] delta_out;
    logic            step_err;
    logic            evt_valid;
    logic [TB_P-1:0] pend_cnt;
    logic            pend_ovf;

    int n_checks       = 0;
    int n_fail         = 0;
    int obs_pops       = 0;
    bit obs_valid_seen = 1'b0;
    bit mon_en         = 1'b0;

    logic [TB_W-1:0] m_hist[$];
    logic [TB_W-1:0] m_base_g;
    int              m_n, m_cnt, m_delta, m_pend, m_base_b;
    bit              m_err, m_ovf;

    cc_cnt_gray_rx #(
        .W           (TB_W),
        .SYNC_STAGES (TB_S),
        .PEND_W      (TB_P)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .gray_in   (gray_in),
        .cnt_out   (cnt_out),
        .delta_out (delta_out),
        .step_err  (step_err),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .pend_cnt  (pend_cnt),
        .pend_ovf  (pend_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [TB_W-1:0] tb_b2g(input int b);
        logic [TB_W-1:0] v;
        v = TB_W'(b);
        return v ^ (v >> 1);
    endfunction

    function automatic int tb_g2b(input logic [TB_W-1:0] g);
        logic [TB_W-1:0] b;
        for (int i = 0; i < TB_W; i++) b[i] = ^(g >> i);
        return int'(b);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    // Count-level reference: the source count seen TB_S edges late, with
    // advances since the baseline turned into queued events.
    always @(posedge clk) begin : p_model
        logic [TB_W-1:0] g_seen;
        int              seen_b, adv;
        bit              pop;
        if (rst) begin
            m_hist.delete();
            for (int i = 0; i < TB_S; i++) m_hist.push_back('0);
            m_n = 0; m_cnt = 0; m_delta = 0; m_pend = 0;
            m_err = 1'b0; m_ovf = 1'b0; m_base_b = 0; m_base_g = '0;
        end else begin
            g_seen = m_hist[$];
            m_hist.push_front(gray_in);
            void'(m_hist.pop_back());
            seen_b = tb_g2b(g_seen);
            pop    = (m_pend != 0) && evt_ready;
            if (m_n < TB_S + 2) m_n++;
            adv = 0;
            if (m_n == TB_S + 2) begin
                adv = (seen_b - m_base_b + 256) % 256;
                if (adv != 0) begin
                    m_delta = adv;
                    if ($countones(g_seen ^ m_base_g) > 1) m_err = 1'b1;
                end
            end
            m_pend = m_pend + adv - (pop ? 1 : 0);
            if (m_pend > PEND_MAX) begin
                m_pend = PEND_MAX;
                m_ovf  = 1'b1;
            end
            m_base_b = seen_b;
            m_base_g = g_seen;
            m_cnt    = seen_b;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("cnt_out",   32'(cnt_out),   32'(m_cnt));
            chk("delta_out", 32'(delta_out), 32'(m_delta));
            chk("step_err",  32'(step_err),  32'(m_err));
            chk("pend_cnt",  32'(pend_cnt),  32'(m_pend));
            chk("pend_ovf",  32'(pend_ovf),  32'(m_ovf));
            chk("evt_valid", 32'(evt_valid), 32'(m_pend != 0));
            if (!rst && evt_valid && evt_ready) obs_pops++;
            if (!rst && evt_valid) obs_valid_seen = 1'b1;
        end
    end

    initial begin
        int cur, r;

        // Plain single-step count with a ready consumer
        gray_in = '0; evt_ready = 1'b1;
        do_reset(2);
        at_neg();
        chk("rst_cnt",   32'(cnt_out),   32'd0);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_pend",  32'(pend_cnt),  32'd0);
        repeat (TB_S + 2) tick();
        obs_pops = 0;
        for (int b = 1; b <= 3; b++) begin
            gray_in = tb_b2g(b);
            repeat (4) tick();
            if (b == 1) begin
                at_neg();
                chk("t1_cnt_first", 32'(cnt_out), 32'd1);
            end
        end
        repeat (3) tick();
        at_neg();
        chk("t1_pops",  32'(obs_pops),  32'd3);
        chk("t1_cnt",   32'(cnt_out),   32'd3);
        chk("t1_delta", 32'(delta_out), 32'd1);
        chk("t1_err",   32'(step_err),  32'd0);

        // Nonzero count held across reset is a baseline, not events
        gray_in = 8'h56; obs_valid_seen = 1'b0;
        do_reset(2);
        obs_pops = 0;
        repeat (10) tick();
        at_neg();
        chk("t2_cnt",   32'(cnt_out),        32'd100);
        chk("t2_valid", 32'(obs_valid_seen), 32'd0);
        chk("t2_pend",  32'(pend_cnt),       32'd0);
        chk("t2_pops",  32'(obs_pops),       32'd0);

        // Queue five events, then drain them back to back
        evt_ready = 1'b0;
        for (int b = 101; b <= 105; b++) begin
            gray_in = tb_b2g(b);
            repeat (2) tick();
        end
        repeat (4) tick();
        at_neg();
        chk("t3_pend",  32'(pend_cnt),  32'd5);
        chk("t3_valid", 32'(evt_valid), 32'd1);
        evt_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            at_neg();
            chk("t3_drain_pend",  32'(pend_cnt),  32'(5 - i));
            chk("t3_drain_valid", 32'(evt_valid), 32'(i < 5));
        end

        // Modular wrap through 255 -> 0
        gray_in = tb_b2g(254);
        do_reset(2);
        repeat (TB_S + 2) tick();
        obs_pops = 0;
        gray_in = tb_b2g(255);
        repeat (3) tick();
        gray_in = tb_b2g(0);
        repeat (4) tick();
        at_neg();
        chk("t4_wrap_cnt", 32'(cnt_out), 32'd0);
        gray_in = tb_b2g(1);
        repeat (4) tick();
        at_neg();
        chk("t4_pops",  32'(obs_pops),  32'd3);
        chk("t4_cnt",   32'(cnt_out),   32'd1);
        chk("t4_delta", 32'(delta_out), 32'd1);
        chk("t4_err",   32'(step_err),  32'd0);

        // Illegal two-bit Gray jump, then reset with events still queued
        gray_in = '0; evt_ready = 1'b0;
        do_reset(2);
        repeat (TB_S + 2) tick();
        gray_in = 8'h03;
        repeat (4) tick();
        at_neg();
        chk("t5_err",   32'(step_err),  32'd1);
        chk("t5_delta", 32'(delta_out), 32'd2);
        chk("t5_pend",  32'(pend_cnt),  32'd2);
        repeat (3) tick();
        at_neg();
        chk("t5_err_sticky", 32'(step_err), 32'd1);
        rst = 1'b1;
        tick();
        at_neg();
        chk("t5_rst_cnt",   32'(cnt_out),   32'd0);
        chk("t5_rst_delta", 32'(delta_out), 32'd0);
        chk("t5_rst_err",   32'(step_err),  32'd0);
        chk("t5_rst_valid", 32'(evt_valid), 32'd0);
        chk("t5_rst_pend",  32'(pend_cnt),  32'd0);
        chk("t5_rst_ovf",   32'(pend_ovf),  32'd0);
        rst = 1'b0;

        // Saturation, then add and pop landing on the same edge
        gray_in = '0; evt_ready = 1'b0;
        do_reset(2);
        repeat (TB_S + 2) tick();
        for (int b = 1; b <= 9; b++) begin
            gray_in = tb_b2g(b);
            repeat (2) tick();
        end
        repeat (4) tick();
        at_neg();
        chk("t6_sat_pend", 32'(pend_cnt), 32'(PEND_MAX));
        chk("t6_sat_ovf",  32'(pend_ovf), 32'd1);
        evt_ready = 1'b1;
        repeat (PEND_MAX - 1) @(posedge clk);
        #2;
        evt_ready = 1'b0;
        at_neg();
        chk("t6_one_left", 32'(pend_cnt), 32'd1);
        gray_in = tb_b2g(10);
        repeat (TB_S) @(posedge clk);
        #2;
        evt_ready = 1'b1;
        @(posedge clk);
        #2;
        evt_ready = 1'b0;
        at_neg();
        chk("t6_add_pop_pend", 32'(pend_cnt), 32'd1);
        chk("t6_add_pop_cnt",  32'(cnt_out),  32'd10);
        chk("t6_ovf_sticky",   32'(pend_ovf), 32'd1);

        // Random walk: mostly increments, occasional jumps, backsteps, resets
        gray_in = '0; evt_ready = 1'b0;
        do_reset(2);
        cur = 0;
        for (int c = 0; c < 800; c++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55)      cur = (cur + 1) % 256;
            else if (r < 58) cur = int'($urandom_range(0, 255));
            else if (r < 60) cur = (cur + 255) % 256;
            gray_in   = tb_b2g(cur);
            evt_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        repeat (6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
